// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon-AEAD128 types and constants, including the permutation round sequencer's.
// PERM_CTRL_DUAL_ROUND_EN selects two rounds per cycle (RND_STEP=2) instead of one.
package ascon_aead128_pkg;

    typedef logic [3:0] round;

    typedef enum logic {
        P12 = 1'b0,
        P8  = 1'b1
    } perm_mode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_ctrl_fsm;

    localparam round P12_FIRST_RND = 4'h4;
    localparam round P8_FIRST_RND  = 4'h8;
    localparam round LAST_RND      = 4'hF;

`ifdef PERM_CTRL_DUAL_ROUND_EN
    localparam round RND_STEP = 4'd2;
`else
    localparam round RND_STEP = 4'd1;
`endif

    // Index held in the counter on the final RUN cycle; the counter never steps past it.
    localparam round RUN_LAST_RND = LAST_RND - RND_STEP + 4'd1;

    function automatic round first_rnd(perm_mode mode);
        return (mode == P8) ? P8_FIRST_RND : P12_FIRST_RND;
    endfunction

    function automatic logic [7:0] const_add(round rnd);
        return {4'h3 - rnd, rnd - 4'h4};
    endfunction

endpackage

// File: rtl/perm_ctrl_if.sv
// Requester/datapath-facing signal bundle of the permutation round sequencer.
// rnd1_o exists only when PERM_CTRL_DUAL_ROUND_EN is defined.
interface perm_ctrl_if;
    import ascon_aead128_pkg::*;

    logic     start_i;
    perm_mode mode_i;
    logic     clear_i;
    logic     ready_o;
    logic     busy_o;
    round     rnd_o;
`ifdef PERM_CTRL_DUAL_ROUND_EN
    round     rnd1_o;
`endif
    logic     rnd_en_o;
    logic     done_o;

`ifdef PERM_CTRL_DUAL_ROUND_EN
    modport master (output start_i, mode_i, clear_i,
                    input  ready_o, busy_o, rnd_o, rnd1_o, rnd_en_o, done_o);
    modport slave  (input  start_i, mode_i, clear_i,
                    output ready_o, busy_o, rnd_o, rnd1_o, rnd_en_o, done_o);
`else
    modport master (output start_i, mode_i, clear_i,
                    input  ready_o, busy_o, rnd_o, rnd_en_o, done_o);
    modport slave  (input  start_i, mode_i, clear_i,
                    output ready_o, busy_o, rnd_o, rnd_en_o, done_o);
`endif

endinterface

// File: rtl/perm_ctrl.sv
// Ascon p^12 / p^8 round sequencer: one round index (or pair) per cycle, all outputs registered.
// PERM_CTRL_DUAL_ROUND_EN enables the two-rounds-per-cycle variant with rnd1_o.
module perm_ctrl
    import ascon_aead128_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    perm_ctrl_if.slave bus
);

    perm_ctrl_fsm state_q, state_d;
    round         cnt_q, cnt_d;
    logic         ready_q, busy_q, rnd_en_q, done_q;
`ifdef PERM_CTRL_DUAL_ROUND_EN
    round         rnd1_q;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        state_d = RUN;
                        cnt_d   = first_rnd(bus.mode_i);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (cnt_q == RUN_LAST_RND) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + RND_STEP;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next state, so they line up with state_q without a comb path from inputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, avoiding evaluation-order races.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            rnd_en_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef PERM_CTRL_DUAL_ROUND_EN
            rnd1_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= (state_d != RUN);
            busy_q   <= (state_d == RUN);
            rnd_en_q <= (state_d == RUN);
            done_q   <= (state_d == DONE);
`ifdef PERM_CTRL_DUAL_ROUND_EN
            rnd1_q   <= (state_d == RUN) ? cnt_d + 4'd1 : '0;
`endif
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
    assign bus.rnd_o    = cnt_q;
    assign bus.rnd_en_o = rnd_en_q;
    assign bus.done_o   = done_q;
`ifdef PERM_CTRL_DUAL_ROUND_EN
    assign bus.rnd1_o   = rnd1_q;
`endif

endmodule
